// File: rtl/wave_ptr_player.sv
// BRAM-to-AXI-Stream waveform playback engine.
// Reads waveform words between a latched start and stop address, tags the
// word read from the stop address as end-of-pass, and streams everything
// through a small prefetch FIFO with a registered AXIS output stage.
module wave_ptr_player #(
   parameter int DATA_W     = 512,
   parameter int ADDR_W     = 12,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int REP_W      = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [ADDR_W-1:0] cfg_start_addr,
   input  logic [ADDR_W-1:0] cfg_stop_addr,
   input  logic [1:0]        cfg_mode,
   input  logic [REP_W-1:0]  cfg_repeat,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              done,
   output logic              err_cfg
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 2;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] start_r, stop_r, ptr;
   logic [1:0]        mode_r;
   logic [REP_W-1:0]  pass_cnt;
   logic              err_r, done_r;

   logic              issue, go, err_set, done_set, drained, at_stop, cfg_bad;
   logic [CNT_W-1:0]  out_cnt;     // reads issued but not yet written into the FIFO
   logic [CNT_W-1:0]  mem_cnt;     // words held in FIFO storage (excludes output register)
   logic [CNT_W-1:0]  occ;

   logic [RD_LAT-1:0] vld_p, last_p;
   logic              wr_en, wr_last;

   logic [DATA_W:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              load, mem_rd, mem_wr;
   logic              out_vld, out_last;
   logic [DATA_W-1:0] out_data;

   assign at_stop = (ptr == stop_r);
   assign cfg_bad = (cfg_stop_addr < cfg_start_addr) || (cfg_mode == 2'd3);
   assign occ     = mem_cnt + out_cnt + CNT_W'(out_vld);
   assign drained = (out_cnt == '0) && (mem_cnt == '0) && !out_vld;

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state, read issue and command decode
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      go        = 1'b0;
      err_set   = 1'b0;
      done_set  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_start) begin
               if (cfg_bad) begin
                  err_set = 1'b1;
               end else begin
                  go        = 1'b1;
                  state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (cmd_stop) begin
               state_nxt = S_DRAIN;
            end else if (occ < DEPTH_C) begin
               issue = 1'b1;
               if (at_stop && ((mode_r == 2'd0) ||
                               ((mode_r == 2'd1) && (pass_cnt <= REP_W'(1)))))
                  state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drained) begin
               done_set  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latched configuration, read pointer and pass counter
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         start_r  <= '0;
         stop_r   <= '0;
         mode_r   <= '0;
         ptr      <= '0;
         pass_cnt <= '0;
      end else if (go) begin
         start_r  <= cfg_start_addr;
         stop_r   <= cfg_stop_addr;
         mode_r   <= cfg_mode;
         ptr      <= cfg_start_addr;
         pass_cnt <= (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
      end else if (issue) begin
         if (!at_stop) begin
            ptr <= ptr + ADDR_W'(1);
         end else begin
            ptr <= start_r;
            if (mode_r == 2'd1) pass_cnt <= pass_cnt - REP_W'(1);
         end
      end
   end

   // Sticky config error and one-cycle done pulse
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= done_set;
         if (go)           err_r <= 1'b0;
         else if (err_set) err_r <= 1'b1;
      end
   end

   // ---- stage boundary: read issue -> BRAM return (RD_LAT cycles) ----
   // Valid/last tag pipe matching the BRAM read latency
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         vld_p  <= '0;
         last_p <= '0;
      end else begin
         vld_p[0]  <= issue;
         last_p[0] <= issue && at_stop;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i]  <= vld_p[i-1];
            last_p[i] <= last_p[i-1];
         end
      end
   end

   assign wr_en   = vld_p[RD_LAT-1];
   assign wr_last = last_p[RD_LAT-1];

   // Outstanding read count: +1 per issue, -1 per return written
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)               out_cnt <= '0;
      else if (issue && !wr_en)   out_cnt <= out_cnt + CNT_W'(1);
      else if (!issue && wr_en)   out_cnt <= out_cnt - CNT_W'(1);
   end

   // ---- stage boundary: BRAM return -> FIFO -> AXIS output register ----
   // Output register reloads whenever it is empty or being consumed; when the
   // storage is empty a returning word bypasses straight into it.
   assign load   = (!out_vld || m_axis_tready) && ((mem_cnt != '0) || wr_en);
   assign mem_rd = load && (mem_cnt != '0);
   assign mem_wr = wr_en && !(load && (mem_cnt == '0));

   // FIFO storage array (data only, no reset)
   always_ff @(posedge aclk) begin
      if (mem_wr) mem[wr_ptr] <= {wr_last, bram_rdata};
   end

   // FIFO pointers and fill count
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
      end else begin
         if (mem_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (mem_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (mem_wr && !mem_rd)      mem_cnt <= mem_cnt + CNT_W'(1);
         else if (!mem_wr && mem_rd) mem_cnt <= mem_cnt - CNT_W'(1);
      end
   end

   // Registered AXIS output stage; holds data/last while stalled
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_vld  <= 1'b0;
         out_last <= 1'b0;
         out_data <= '0;
      end else if (load) begin
         out_vld <= 1'b1;
         if (mem_cnt != '0) {out_last, out_data} <= mem[rd_ptr];
         else               {out_last, out_data} <= {wr_last, bram_rdata};
      end else if (out_vld && m_axis_tready) begin
         out_vld <= 1'b0;
      end
   end

   assign bram_en       = issue;
   assign bram_addr     = ptr;
   assign m_axis_tdata  = out_data;
   assign m_axis_tvalid = out_vld;
   assign m_axis_tlast  = out_last;
   assign busy          = (state != S_IDLE);
   assign done          = done_r;
   assign err_cfg       = err_r;

endmodule
